parking_gate_ctrl: RTL

- Gate-side controller and sole writer of the per-slot occupancy vector that the lot display logic reads.
- Arbitrates entry and exit requests, and allocates the lowest free slot on entry.
- Drives a single barrier through an open/timeout FSM.
- Commits occupancy changes only after the car is confirmed through the gate.

---
 rtl/parking_gate_ctrl_pkg.sv | 14 +
 rtl/parking_gate_ctrl_if.sv | 65 ++++++
 rtl/parking_gate_ctrl_free_slot_finder.sv | 26 ++
 rtl/parking_gate_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and defaults for the parking gate controller.
// Optional macro PARKING_OCC_COUNT_EN enables the registered occupancy count.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN_IN,
    OPEN_OUT
  } gate_state_t;

  localparam int NUM_SLOTS_DEF        = 8;
  localparam int GATE_OPEN_CYCLES_DEF = 16;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Request/grant and status bundle between the gate and the controller.
// Carries occ_count only when PARKING_OCC_COUNT_EN is defined.
interface parking_gate_ctrl_if
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) ();

  logic                 entry_req;
  logic                 exit_req;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 pass_sensor;
  logic                 entry_ack;
  logic                 exit_ack;
  logic                 reject;
  logic                 exit_err;
  logic [SLOT_W-1:0]    assigned_slot;
  logic                 gate_open;
  logic                 busy;
  logic                 full;
  logic [NUM_SLOTS-1:0] slot_occupied;
`ifdef PARKING_OCC_COUNT_EN
  logic [SLOT_W:0]      occ_count;
`endif

  modport master (
`ifdef PARKING_OCC_COUNT_EN
    input  occ_count,
`endif
    output entry_req,
    output exit_req,
    output exit_slot,
    output pass_sensor,
    input  entry_ack,
    input  exit_ack,
    input  reject,
    input  exit_err,
    input  assigned_slot,
    input  gate_open,
    input  busy,
    input  full,
    input  slot_occupied
  );

  modport slave (
`ifdef PARKING_OCC_COUNT_EN
    output occ_count,
`endif
    input  entry_req,
    input  exit_req,
    input  exit_slot,
    input  pass_sensor,
    output entry_ack,
    output exit_ack,
    output reject,
    output exit_err,
    output assigned_slot,
    output gate_open,
    output busy,
    output full,
    output slot_occupied
  );

endinterface

// File: rtl/parking_gate_ctrl_free_slot_finder.sv
// Lowest-zero priority encoder over the occupancy map.
// Does not depend on PARKING_OCC_COUNT_EN.
module free_slot_finder
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] slot_occupied,
  output logic [SLOT_W-1:0]    slot,
  output logic                 any_free
);

  // Scan downward so the lowest free index is written last.
  always_comb begin
    slot     = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_occupied[i]) begin
        slot     = SLOT_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Gate controller: arbitration, slot allocation, barrier FSM, occupancy.
// Define PARKING_OCC_COUNT_EN to add the registered occ_count output.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS        = NUM_SLOTS_DEF,
  parameter int SLOT_W           = $clog2(NUM_SLOTS),
  parameter int GATE_OPEN_CYCLES = GATE_OPEN_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  parking_gate_ctrl_if.slave  bus
);

  localparam int TW = (GATE_OPEN_CYCLES > 2) ?
                      $clog2(GATE_OPEN_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(GATE_OPEN_CYCLES - 1);

  gate_state_t          state;
  logic [TW-1:0]        timer;
  logic [SLOT_W-1:0]    exit_slot_q;
  logic [SLOT_W-1:0]    free_slot;
  logic                 any_free;

  free_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_finder (
    .slot_occupied (bus.slot_occupied),
    .slot          (free_slot),
    .any_free      (any_free)
  );

`ifdef PARKING_OCC_COUNT_EN
  assign bus.full = (bus.occ_count == (SLOT_W+1)'(NUM_SLOTS));
`else
  assign bus.full = &bus.slot_occupied;
`endif

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      timer             <= '0;
      exit_slot_q       <= '0;
      bus.entry_ack     <= 1'b0;
      bus.exit_ack      <= 1'b0;
      bus.reject        <= 1'b0;
      bus.exit_err      <= 1'b0;
      bus.assigned_slot <= '0;
      bus.gate_open     <= 1'b0;
      bus.slot_occupied <= '0;
`ifdef PARKING_OCC_COUNT_EN
      bus.occ_count     <= '0;
`endif
    end else begin
      bus.entry_ack <= 1'b0;
      bus.exit_ack  <= 1'b0;
      bus.reject    <= 1'b0;
      bus.exit_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          priority case (1'b1)
            bus.exit_req && bus.slot_occupied[bus.exit_slot]: begin
              bus.exit_ack <= 1'b1;
              exit_slot_q  <= bus.exit_slot;
              timer        <= '0;
              state        <= OPEN_OUT;
            end
            bus.exit_req: bus.exit_err <= 1'b1;
            bus.entry_req && !bus.full && any_free: begin
              bus.entry_ack     <= 1'b1;
              bus.assigned_slot <= free_slot;
              timer             <= '0;
              state             <= OPEN_IN;
            end
            bus.entry_req: bus.reject <= 1'b1;
            default: ;
          endcase
        end
        OPEN_IN, OPEN_OUT: begin
          // The ack cycle keeps the barrier shut; it opens one cycle later.
          if (bus.pass_sensor) begin
            if (state == OPEN_IN) begin
              bus.slot_occupied[bus.assigned_slot] <= 1'b1;
`ifdef PARKING_OCC_COUNT_EN
              bus.occ_count <= bus.occ_count + 1'b1;
`endif
            end else begin
              bus.slot_occupied[exit_slot_q] <= 1'b0;
`ifdef PARKING_OCC_COUNT_EN
              bus.occ_count <= bus.occ_count - 1'b1;
`endif
            end
            bus.gate_open <= 1'b0;
            timer         <= '0;
            state         <= IDLE;
          end else if (!bus.gate_open) begin
            bus.gate_open <= 1'b1;
          end else if (timer == T_LAST) begin
            bus.gate_open <= 1'b0;
            timer         <= '0;
            state         <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
